mux_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 4:1 gate-level multiplexer between four

---
 rtl/mux_rr_arbiter.sv | 105 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of a shared 4:1 mux. It drives the mux select,
// waits SETTLE_CYC cycles for the mux path to settle, and then grants the
// selected requester. Each ownership lasts at most MAX_HOLD cycles.
module mux_rr_arbiter #(
  parameter int SETTLE_CYC = 1,
  parameter int MAX_HOLD   = 8,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       expired
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_GRANT  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic [2:0]       settle_cnt;
  logic [CNT_W-1:0] hold;

  // Pick the first requester at or after ptr, wrapping modulo 4.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Arbitration state machine. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      expired    <= 1'b0;
      ptr        <= '0;
      settle_cnt <= '0;
      hold       <= '0;
    end else begin
      expired <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            sel        <= win;
            busy       <= 1'b1;
            settle_cnt <= '0;
            if (SETTLE_CYC == 0) begin
              state <= ST_GRANT;
              gnt   <= 4'b0001 << win;
              hold  <= CNT_W'(1);
            end else begin
              state <= ST_SETTLE;
              hold  <= '0;
            end
          end
        end
        ST_SETTLE: begin
          // The owner's request is not checked here; it is checked in GRANT.
          if (settle_cnt == 3'(SETTLE_CYC - 1)) begin
            state <= ST_GRANT;
            gnt   <= 4'b0001 << sel;
            hold  <= CNT_W'(1);
          end else begin
            settle_cnt <= settle_cnt + 3'd1;
          end
        end
        ST_GRANT: begin
          // hold counts the grant cycles so far, including the current one.
          if (!req[sel] || hold == CNT_W'(MAX_HOLD)) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            ptr     <= sel + 2'd1;
            expired <= req[sel];
            hold    <= '0;
          end else if (hold != '1) begin
            hold <= hold + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter: one instance with the
// default settle interval and one with SETTLE_CYC=0.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_a, req_b;
  logic [1:0] sel_a, sel_b;
  logic [3:0] gnt_a, gnt_b;
  logic       busy_a, busy_b, expired_a, expired_b;

  int n_cmp = 0;
  int n_bad = 0;

  mux_rr_arbiter #(.SETTLE_CYC(1), .MAX_HOLD(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .sel(sel_a),
    .gnt(gnt_a), .busy(busy_a), .expired(expired_a)
  );

  mux_rr_arbiter #(.SETTLE_CYC(0), .MAX_HOLD(8), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .sel(sel_b),
    .gnt(gnt_b), .busy(busy_b), .expired(expired_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (gnt_a !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt_a); end
    n_cmp++; if (sel_a !== 2'b00) begin n_bad++; $display("FAIL reset_sel got=%b exp=00", sel_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    n_cmp++; if (expired_a !== 1'b0) begin n_bad++; $display("FAIL reset_expired got=%b exp=0", expired_a); end
    n_cmp++; if (gnt_b !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt_b got=%b exp=0000", gnt_b); end
  endtask

  task automatic test_single();
    do_reset();
    req_a = 4'b0001;
    tick();
    n_cmp++; if (sel_a !== 2'b00 || busy_a !== 1'b1 || gnt_a !== 4'b0000) begin
      n_bad++; $display("FAIL single_settle sel=%b busy=%b gnt=%b exp 00/1/0000", sel_a, busy_a, gnt_a); end
    tick();
    n_cmp++; if (gnt_a !== 4'b0001) begin n_bad++; $display("FAIL single_grant got=%b exp=0001", gnt_a); end
    req_a = 4'b0000;
    tick();
    n_cmp++; if (gnt_a !== 4'b0000 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL single_release gnt=%b busy=%b exp 0000/0", gnt_a, busy_a); end
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      tick();
      n_cmp++; if (sel_a !== 2'(w) || busy_a !== 1'b1 || gnt_a !== 4'b0000) begin
        n_bad++; $display("FAIL rr_settle k=%0d sel=%b busy=%b gnt=%b exp sel=%0d busy=1 gnt=0000", k, sel_a, busy_a, gnt_a, w); end
      for (int c = 0; c < 3; c++) begin
        tick();
        n_cmp++; if (gnt_a !== (4'b0001 << w)) begin
          n_bad++; $display("FAIL rr_grant k=%0d cyc=%0d got=%b exp=%b", k, c, gnt_a, 4'b0001 << w); end
      end
      req_a[w] = 1'b0;
      tick();
      n_cmp++; if (gnt_a !== 4'b0000 || busy_a !== 1'b0 || sel_a !== 2'(w)) begin
        n_bad++; $display("FAIL rr_idle k=%0d gnt=%b busy=%b sel=%b exp 0000/0/%0d", k, gnt_a, busy_a, sel_a, w); end
      req_a[w] = 1'b1;
    end
    req_a = '0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req_a = 4'b0100;
    tick();
    n_cmp++; if (sel_a !== 2'b10) begin n_bad++; $display("FAIL to_sel got=%b exp=10", sel_a); end
    for (int c = 0; c < 8; c++) begin
      tick();
      n_cmp++; if (gnt_a !== 4'b0100 || expired_a !== 1'b0) begin
        n_bad++; $display("FAIL to_hold cyc=%0d gnt=%b expired=%b exp 0100/0", c, gnt_a, expired_a); end
    end
    tick();
    n_cmp++; if (gnt_a !== 4'b0000 || expired_a !== 1'b1 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL to_expire gnt=%b expired=%b busy=%b exp 0000/1/0", gnt_a, expired_a, busy_a); end
    tick();
    n_cmp++; if (expired_a !== 1'b0 || busy_a !== 1'b1 || sel_a !== 2'b10) begin
      n_bad++; $display("FAIL to_rearb expired=%b busy=%b sel=%b exp 0/1/10", expired_a, busy_a, sel_a); end
    tick();
    n_cmp++; if (gnt_a !== 4'b0100) begin n_bad++; $display("FAIL to_regrant got=%b exp=0100", gnt_a); end
    req_a = '0;
    tick();
  endtask

  task automatic test_no_preempt();
    do_reset();
    req_a = 4'b0010;
    tick();
    tick();
    n_cmp++; if (gnt_a !== 4'b0010) begin n_bad++; $display("FAIL np_grant got=%b exp=0010", gnt_a); end
    req_a = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (gnt_a !== 4'b0010 || sel_a !== 2'b01) begin
        n_bad++; $display("FAIL np_hold cyc=%0d gnt=%b sel=%b exp 0010/01", c, gnt_a, sel_a); end
    end
    req_a = 4'b1000;
    tick();
    n_cmp++; if (gnt_a !== 4'b0000 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL np_release gnt=%b busy=%b exp 0000/0", gnt_a, busy_a); end
    tick();
    n_cmp++; if (sel_a !== 2'b11) begin n_bad++; $display("FAIL np_sel got=%b exp=11", sel_a); end
    tick();
    n_cmp++; if (gnt_a !== 4'b1000) begin n_bad++; $display("FAIL np_next got=%b exp=1000", gnt_a); end
    req_a = '0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_a = 4'b0100;
    tick();
    tick();
    req_a = 4'b1111;
    tick();
    n_cmp++; if (gnt_a !== 4'b0100) begin n_bad++; $display("FAIL mr_pre got=%b exp=0100", gnt_a); end
    rst = 1'b1;
    tick();
    n_cmp++; if (gnt_a !== 4'b0000 || sel_a !== 2'b00 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL mr_reset gnt=%b sel=%b busy=%b exp 0000/00/0", gnt_a, sel_a, busy_a); end
    rst = 1'b0;
    tick();
    n_cmp++; if (sel_a !== 2'b00 || busy_a !== 1'b1) begin
      n_bad++; $display("FAIL mr_settle sel=%b busy=%b exp 00/1", sel_a, busy_a); end
    tick();
    n_cmp++; if (gnt_a !== 4'b0001) begin n_bad++; $display("FAIL mr_first got=%b exp=0001", gnt_a); end
    req_a = '0;
    tick();
  endtask

  task automatic test_zero_settle();
    do_reset();
    req_b = 4'b1000;
    tick();
    n_cmp++; if (sel_b !== 2'b11 || gnt_b !== 4'b1000 || busy_b !== 1'b1) begin
      n_bad++; $display("FAIL zs_grant sel=%b gnt=%b busy=%b exp 11/1000/1", sel_b, gnt_b, busy_b); end
    req_b = 4'b0000;
    tick();
    n_cmp++; if (gnt_b !== 4'b0000 || busy_b !== 1'b0) begin
      n_bad++; $display("FAIL zs_release gnt=%b busy=%b exp 0000/0", gnt_b, busy_b); end
    req_b = 4'b1001;
    tick();
    n_cmp++; if (sel_b !== 2'b00 || gnt_b !== 4'b0001) begin
      n_bad++; $display("FAIL zs_wrap sel=%b gnt=%b exp 00/0001", sel_b, gnt_b); end
    req_b = '0;
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_no_preempt();
    test_reset_mid_grant();
    test_zero_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
